// File: rtl/simplebus_ram_slave.sv
// SimpleBus slave backed by an on-chip 64-bit word RAM.
// Serves single, wrapping-burst reads and masked single/burst writes, one transaction at a time.
module simplebus_ram_slave #(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int BURST_BEATS     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_cmd,
  input  logic [7:0]  req_wmask,
  input  logic [63:0] req_wdata,
  input  logic [15:0] req_user,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [3:0]  resp_cmd,
  output logic [63:0] resp_rdata,
  output logic [15:0] resp_user
);

  localparam int BEAT_BITS = $clog2(BURST_BEATS);
  localparam int LINE_BITS = ADDR_WORDS_LOG2 - BEAT_BITS;
  localparam int DEPTH     = 1 << ADDR_WORDS_LOG2;

  localparam logic [3:0] CMD_READ        = 4'b0000;
  localparam logic [3:0] CMD_WRITE       = 4'b0001;
  localparam logic [3:0] CMD_READ_BURST  = 4'b0010;
  localparam logic [3:0] CMD_WRITE_BURST = 4'b0011;
  localparam logic [3:0] CMD_WRITE_LAST  = 4'b0111;

  localparam logic [3:0] RSP_READ_LAST  = 4'b0110;
  localparam logic [3:0] RSP_READ_BEAT  = 4'b0010;
  localparam logic [3:0] RSP_WRITE_RESP = 4'b0101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WBURST = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_RBURST = 2'd3;

  localparam logic [BEAT_BITS-1:0] LAST_COUNT   = BEAT_BITS'(BURST_BEATS - 1);
  localparam logic [BEAT_BITS-1:0] PENULT_COUNT = BEAT_BITS'(BURST_BEATS - 2);

  logic [63:0] mem [DEPTH];

  logic [1:0]                 state;
  logic [LINE_BITS-1:0]       line;
  logic [BEAT_BITS-1:0]       beat;
  logic [BEAT_BITS-1:0]       beat_next;
  logic [BEAT_BITS-1:0]       count;
  logic [ADDR_WORDS_LOG2-1:0] word_idx;
  logic [ADDR_WORDS_LOG2-1:0] burst_idx;
  logic [ADDR_WORDS_LOG2-1:0] next_burst_idx;
  logic [ADDR_WORDS_LOG2-1:0] wr_idx;
  logic                       accept;
  logic                       ram_we;
  logic                       unused_inputs;

  assign unused_inputs  = ^{req_size, req_addr[31:ADDR_WORDS_LOG2+3], req_addr[2:0]};
  assign word_idx       = req_addr[ADDR_WORDS_LOG2+2:3];
  assign beat_next      = beat + 1'b1;
  assign burst_idx      = {line, beat};
  assign next_burst_idx = {line, beat_next};
  assign accept         = req_valid && req_ready;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wmask);
    logic [63:0] merged;
    merged = old_word;
    for (int b = 0; b < 8; b++) begin
      if (wmask[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

  // Burst beats after the first ignore req_addr and land at line|beat.
  always_comb begin
    ram_we = 1'b0;
    wr_idx = word_idx;
    if (reset && accept) begin
      if (state == ST_WBURST) begin
        ram_we = 1'b1;
        wr_idx = burst_idx;
      end else if (state == ST_IDLE &&
                   (req_cmd == CMD_WRITE || req_cmd == CMD_WRITE_LAST ||
                    req_cmd == CMD_WRITE_BURST)) begin
        ram_we = 1'b1;
      end
    end
  end

  // RAM has no reset so accepted writes survive a mid-operation reset.
  always_ff @(posedge clock) begin
    if (ram_we) mem[wr_idx] <= merge_bytes(mem[wr_idx], req_wdata, req_wmask);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_cmd   <= '0;
      resp_rdata <= '0;
      resp_user  <= '0;
      line       <= '0;
      beat       <= '0;
      count      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            resp_user <= req_user;
            case (req_cmd)
              CMD_READ: begin
                resp_valid <= 1'b1;
                resp_cmd   <= RSP_READ_LAST;
                resp_rdata <= mem[word_idx];
                req_ready  <= 1'b0;
                state      <= ST_RESP;
              end
              CMD_WRITE, CMD_WRITE_LAST: begin
                resp_valid <= 1'b1;
                resp_cmd   <= RSP_WRITE_RESP;
                resp_rdata <= '0;
                req_ready  <= 1'b0;
                state      <= ST_RESP;
              end
              CMD_READ_BURST: begin
                line       <= word_idx[ADDR_WORDS_LOG2-1:BEAT_BITS];
                beat       <= word_idx[BEAT_BITS-1:0];
                count      <= '0;
                resp_valid <= 1'b1;
                resp_cmd   <= RSP_READ_BEAT;
                resp_rdata <= mem[word_idx];
                req_ready  <= 1'b0;
                state      <= ST_RBURST;
              end
              CMD_WRITE_BURST: begin
                line  <= word_idx[ADDR_WORDS_LOG2-1:BEAT_BITS];
                beat  <= word_idx[BEAT_BITS-1:0] + 1'b1;
                state <= ST_WBURST;
              end
              default: begin
                resp_valid <= 1'b1;
                resp_cmd   <= RSP_READ_LAST;
                resp_rdata <= '0;
                req_ready  <= 1'b0;
                state      <= ST_RESP;
              end
            endcase
          end
        end
        ST_WBURST: begin
          if (accept) begin
            beat <= beat_next;
            if (req_cmd == CMD_WRITE_LAST) begin
              resp_valid <= 1'b1;
              resp_cmd   <= RSP_WRITE_RESP;
              resp_rdata <= '0;
              resp_user  <= req_user;
              req_ready  <= 1'b0;
              state      <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_RBURST: begin
          if (resp_ready) begin
            if (count == LAST_COUNT) begin
              resp_valid <= 1'b0;
              req_ready  <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              count      <= count + 1'b1;
              beat       <= beat_next;
              resp_rdata <= mem[next_burst_idx];
              resp_cmd   <= (count == PENULT_COUNT) ? RSP_READ_LAST : RSP_READ_BEAT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/simplebus_ram_slave.md
# simplebus_ram_slave

Synthesizable SimpleBus slave that terminates a single SimpleBus port with an on-chip word-addressed RAM. It sits directly downstream of the simplebus bus boundary in the ntcache environment and consumes cache refill/writeback traffic. Single, critical-word-first and wrapping burst reads, masked single writes and burst writes are served with one transaction outstanding and fully back-pressurable responses.

## Interface
- Parameters:
- ADDR_WORDS_LOG2, 10: RAM depth = 2^ADDR_WORDS_LOG2 64-bit words
- BURST_BEATS, 8: beats per burst line; power of two, 2..16
- Ports:
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clock rising edge
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid && ready
- req_addr  in  32  byte address; word index = req_addr[ADDR_WORDS_LOG2+2:3], higher bits ignored
- req_size  in  3  ignored; byte enables come from req_wmask
- req_cmd  in  4  command
- req_wmask  in  8  per-byte write enable
- req_wdata  in  64  write data
- req_user  in  16  tag, echoed on response
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid && ready
- resp_cmd  out  4  response command
- resp_rdata  out  64  read data
- resp_user  out  16  req_user of the owning request

## Operation
- Commands: 0000 read, 0001 write, 0010 readBurst, 0011 writeBurst beat, 0111 writeLast; any other code is "other".
- Response codes: 0110 readLast, 0010 read beat (non-last), 0101 writeResp.
- FSM states: IDLE, WBURST, RESP, RBURST.
- IDLE (req_ready=1), on accept:
- 0000: read RAM at word index -> RESP, resp_cmd=0110.
- 0001 or 0111: byte-masked write -> RESP, resp_cmd=0101, rdata=0.
- 0010: latch base = index with low log2(BEATS) bits cleared, beat = low bits of index, count = 0 -> RBURST.
- 0011: masked write at index, latch base/beat, beat+1 -> WBURST.
- other: no RAM effect -> RESP, resp_cmd=0110, rdata=0.
- WBURST (req_ready=1): every accepted beat writes at base|beat (req_addr ignored), beat increments mod BURST_BEATS; cmd 0111 -> RESP with 0101; any other cmd is treated as 0011.
- RESP (req_ready=0): hold resp_valid=1 and all resp_* stable until resp_ready; then -> IDLE.
- RBURST (req_ready=0): present RAM[base|beat]; on handshake beat increments mod BURST_BEATS, count+1; beats 0..BURST_BEATS-2 carry 0010, final beat 0110; after final handshake -> IDLE.
- resp_user = req_user latched at the accepting handshake (first beat for writeBurst, since writeLast has its own user: use writeLast's req_user).
- Wrap-around: index and burst beat wrap within RAM depth and within the aligned line respectively; no error signalled.
- RAM contents undefined after power-up and unaffected by reset.

## Timing
- Reset (reset=0 at edge): next cycle req_ready=0, resp_valid=0, resp_cmd=0, resp_rdata=0, resp_user=0, state IDLE; req_ready rises the first cycle after reset is released.
- Reset mid-operation aborts any burst/response at the next edge; writes already accepted remain in RAM.
- Single read/write: accept at edge N, resp_valid=1 from cycle N+1; with resp_ready=1 back-to-back throughput is one transaction per 2 cycles.
- Burst read: first beat valid cycle N+1, one beat per cycle while resp_ready=1; total BURST_BEATS+1 cycles minimum.
- Write burst beats accepted one per cycle; writeResp one cycle after writeLast accept.
- resp_* outputs registered; no combinational path from req_* or resp_ready to any output.
- A RAM write and a later read of the same word in consecutive transactions return new data.

## Test plan
- Reset held 3 cycles with req_valid=1 -> req_ready=0, resp_valid=0, all resp_* 0; req_ready=1 cycle after release.
- Write 0001 addr 0x40, wdata 0x1122334455667788, wmask 0x0F, user 0x00A5 then read 0x40 -> writeResp 0101 user 0x00A5; readLast 0110 with rdata low 32 bits 0x55667788, upper bytes unchanged.
- Preload line 0x100..0x13F with word i = i; readBurst addr 0x128 -> beats 5,6,7,0,1,2,3,4, cmds 0010x7 then 0110.
- Same burst with resp_ready toggling 1/0 each cycle -> identical sequence, data stable while stalled, req_ready=0 throughout.
- writeBurst starting 0x200, 7x0011 + 0111 with data 0xA0..0xA7 -> single 0101 after last; readBurst 0x200 returns 0xA0..0xA7.
- Assert reset during beat 3 of a burst read -> resp_valid=0 next cycle, IDLE, next single read served normally.
